// File: rtl/icache_param_if.sv
// Fetch-side and refill-side bus bundle shared by the instruction cache and its environment.
// Latency: none, this is wiring only.
// Backpressure: the refill side stalls through iwait; the fetch side waits on ihit.
//
// Port summary
//   Fetch:  imemREN, imemaddr   (datapath -> cache)
//           ihit, imemload      (cache -> datapath)
//   Refill: iREN, iaddr         (cache -> memory controller)
//           iwait, iload        (memory controller -> cache)
//
// The slave modport is the cache. The master modport is everything around it:
// the datapath fetch unit and the memory controller.
interface icache_param_if;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;

   modport slave (
      input  imemREN, imemaddr, iwait, iload,
      output ihit, imemload, iREN, iaddr
   );

   modport master (
      output imemREN, imemaddr, iwait, iload,
      input  ihit, imemload, iREN, iaddr
   );
endinterface

// File: rtl/icache_param.sv
// Direct-mapped instruction cache with multi-word burst refill, flush walk and perf counters.
// Latency: a hit takes 0 cycles; a miss takes 1 + BLK_WORDS accepted words + stall cycles + 1.
// Backpressure: the refill burst holds iaddr while iwait=1, and fetches see ihit=0 until the line lands.
//
// Port summary
//   CLK, RST        clock, synchronous active-high reset
//   bus (slave)     fetch port (imemREN/imemaddr/ihit/imemload) and refill port (iREN/iaddr/iwait/iload)
//   flush           level request to invalidate every line
//   flush_done      high in the final cycle of the flush walk
//   hit_count       saturating count of ihit cycles
//   miss_count      saturating count of refills started
module icache_param #(
   parameter int SETS      = 16,
   parameter int BLK_WORDS = 2,
   parameter int CNT_W     = 32
) (
   input  logic             CLK,
   input  logic             RST,
   icache_param_if.slave    bus,
   input  logic             flush,
   output logic             flush_done,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   localparam int OW  = $clog2(BLK_WORDS);
   localparam int OWX = (OW > 0) ? OW : 1;   // keeps the word counter at least 1 bit wide
   localparam int IW  = $clog2(SETS);
   localparam int TW  = 30 - OW - IW;

   typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_t;

   state_t state_q, state_n;

   logic [31:0]     data_q [SETS][BLK_WORDS];
   logic [TW-1:0]   tag_q  [SETS];
   logic [SETS-1:0] valid_q;

   logic [TW-1:0]   ref_tag_q;
   logic [IW-1:0]   ref_idx_q;
   logic [OWX-1:0]  wcnt_q;
   logic [IW-1:0]   fcnt_q;

   logic [TW-1:0]   req_tag;
   logic [IW-1:0]   req_idx;
   logic [OWX-1:0]  req_off;
   logic [31:0]     refill_addr;
   logic            addr_unused;

   logic            tag_hit;
   logic            ihit_c;
   logic            miss_start;
   logic            accept;
   logic            last_word;
   logic            flush_last;
   logic            iren_c;
   logic [31:0]     iaddr_c;
   logic            flush_done_c;

   // Byte-lane bits never reach the cache.
   assign addr_unused = ^bus.imemaddr[1:0];

   assign req_tag = bus.imemaddr[31 -: TW];
   assign req_idx = bus.imemaddr[2+OW +: IW];

   generate
      if (OW > 0) begin : g_word_off
         assign req_off     = bus.imemaddr[2 +: OW];
         assign refill_addr = {ref_tag_q, ref_idx_q, wcnt_q, 2'b00};
      end else begin : g_no_word_off
         assign req_off     = '0;
         assign refill_addr = {ref_tag_q, ref_idx_q, 2'b00};
      end
   endgenerate

   assign tag_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   // A pending flush masks the fetch entirely: no hit, no miss.
   assign ihit_c     = (state_q == IDLE) && !flush && bus.imemREN && tag_hit;
   assign miss_start = (state_q == IDLE) && !flush && bus.imemREN && !tag_hit;
   assign accept     = (state_q == REFILL) && !bus.iwait;
   assign last_word  = (wcnt_q == OWX'(BLK_WORDS - 1));
   assign flush_last = (state_q == FLUSH) && (fcnt_q == IW'(SETS - 1));

   always_comb begin
      state_n      = state_q;
      iren_c       = 1'b0;
      iaddr_c      = '0;
      flush_done_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (flush)
               state_n = FLUSH;
            else if (miss_start)
               state_n = REFILL;
         end
         REFILL: begin
            iren_c  = 1'b1;
            iaddr_c = refill_addr;
            if (accept && last_word)
               state_n = IDLE;
         end
         FLUSH: begin
            // Done is raised in the cycle that clears the last set so the
            // requester can drop flush before the cache is back in IDLE.
            flush_done_c = flush_last;
            if (flush_last)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.ihit     = ihit_c;
   assign bus.imemload = data_q[req_idx][req_off];
   assign bus.iREN     = iren_c;
   assign bus.iaddr    = iaddr_c;
   assign flush_done   = flush_done_c;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         ref_tag_q  <= '0;
         ref_idx_q  <= '0;
         wcnt_q     <= '0;
         fcnt_q     <= '0;
         hit_count  <= '0;
         miss_count <= '0;
         for (int s = 0; s < SETS; s++) begin
            tag_q[s] <= '0;
            for (int w = 0; w < BLK_WORDS; w++)
               data_q[s][w] <= '0;
         end
      end else begin
         state_q <= state_n;

         if ((state_q == IDLE) && flush)
            fcnt_q <= '0;

         // The burst runs from the latched block base, so fetch-side changes
         // during the refill cannot redirect it.
         if (miss_start) begin
            ref_tag_q <= req_tag;
            ref_idx_q <= req_idx;
            wcnt_q    <= '0;
         end

         if (accept) begin
            data_q[ref_idx_q][wcnt_q] <= bus.iload;
            if (last_word) begin
               tag_q[ref_idx_q]   <= ref_tag_q;
               valid_q[ref_idx_q] <= 1'b1;
            end else begin
               wcnt_q <= wcnt_q + OWX'(1);
            end
         end

         if (state_q == FLUSH) begin
            valid_q[fcnt_q] <= 1'b0;
            fcnt_q          <= fcnt_q + IW'(1);
         end

         if (ihit_c && (hit_count != '1))
            hit_count <= hit_count + CNT_W'(1);
         if (miss_start && (miss_count != '1))
            miss_count <= miss_count + CNT_W'(1);
      end
   end

endmodule

// File: doc/icache_param.md
Name: icache_param

Overview:
- Parametrised instruction cache that is the next generation of the team's 16-entry, 1-word-per-block direct-mapped icache.
- Direct-mapped with configurable set count and block size (multi-word burst refill). Adds a whole-cache flush walk and saturating hit/miss performance counters.
- Sits between the datapath fetch port and the memory controller's instruction port. Serves `imemaddr` reads with a combinational hit path.

Parameters:
- SETS, 16, number of cache lines; power of 2, ≥2.
- BLK_WORDS, 2, 32-bit words per line; power of 2, ≥1.
- CNT_W, 32, width of the hit/miss counters.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits[1:0] ignored.
- ihit  out  1  fetch satisfied this cycle.
- imemload  out  32  fetched instruction; valid when ihit=1.
- iREN  out  1  refill read request to the memory controller.
- iaddr  out  32  refill word address.
- iwait  in  1  memory controller busy; iload is valid in a cycle where iREN=1 and iwait=0.
- iload  in  32  refill data.
- flush  in  1  level request to invalidate the whole cache.
- flush_done  out  1  one-cycle pulse when the flush walk completes.
- hit_count  out  CNT_W  saturating count of ihit cycles.
- miss_count  out  CNT_W  saturating count of refills started.

Behaviour:
- Address split (OW = log2 BLK_WORDS, IW = log2 SETS):
  - word offset = addr[2+OW-1:2] (absent when BLK_WORDS=1).
  - index = addr[2+OW+IW-1:2+OW].
  - tag = addr[31:2+OW+IW].
- Storage: data[SETS][BLK_WORDS], tag[SETS], valid[SETS].
- Reset (RST high at posedge):
  - All valid cleared, data and tags cleared to 0.
  - State = IDLE; counters = 0.
  - iREN = 0, iaddr = 0, ihit = 0, flush_done = 0.
  - RST mid-refill or mid-flush aborts the operation; the line being refilled stays invalid.
- ihit is combinational: state == IDLE && !flush && imemREN && valid[idx] && tag[idx] == tag. It does not depend on iwait.
- imemload = data[idx][word offset] at all times.
- FSM states: IDLE, REFILL, FLUSH.
- IDLE:
  - If flush is high, go to FLUSH with fcnt = 0. Flush has priority over a fetch; no hit and no miss is counted that cycle.
  - Else if imemREN && !hit: latch the block base (tag, idx), set wcnt = 0, increment miss_count, go to REFILL.
  - Else stay in IDLE.
- REFILL:
  - iREN = 1 and iaddr = {latched tag, latched idx, wcnt, 2'b00}. Bursts are always block-aligned, starting at word 0.
  - On a cycle with iwait = 0: data[idx][wcnt] <= iload and wcnt increments.
  - When the last word (wcnt == BLK_WORDS-1) is accepted: write tag, set valid, go to IDLE. The next cycle hits if imemaddr still maps to the line.
  - The latched address is used throughout. Changes on imemaddr or imemREN mid-refill do not alter the burst.
  - A flush raised during REFILL is serviced after the refill completes.
- FLUSH:
  - Each cycle clears valid[fcnt] and increments fcnt. SETS cycles in total.
  - On the last set: pulse flush_done for one cycle and go to IDLE.
  - If flush is still high in IDLE, another walk starts; the requester drops flush on flush_done.
  - iREN = 0 throughout.
- iREN and iaddr are 0 in IDLE and FLUSH.
- Counters saturate at 2^CNT_W - 1 and never wrap. hit_count increments on every ihit cycle.
- Latency:
  - Hit: 0 cycles.
  - Miss: 1 cycle (IDLE→REFILL) + BLK_WORDS accepted words + stall cycles + 1 cycle back in IDLE.

Test Plan:
- Cold miss refill (SETS=16, BLK_WORDS=2, iwait=0 every cycle): imemREN=1, imemaddr=0x0000_0040.
  - Required: iREN=1 with iaddr=0x40 then 0x44; return iload 0xAAAA_0001, 0xAAAA_0002.
  - Then ihit=1 with imemload=0xAAAA_0001; miss_count=1.
  - A following read of 0x44 hits with imemload=0xAAAA_0002 in 0 cycles.
- Stalled refill: hold iwait=1 for 3 cycles before each word.
  - Required: iaddr holds each word address while stalled; data captured only when iwait=0.
  - The line becomes valid after exactly 2 accepted words.
- Conflict eviction: fill 0x40, then read 0x440 (same idx=8, tag=8).
  - Required: refill of 0x440/0x444; a subsequent read of 0x40 misses again; miss_count=3.
- Flush: with lines 0x40 and 0x80 valid, assert flush for 1+ cycles.
  - Required: flush_done pulses exactly 16 cycles after FLUSH entry; ihit=0 throughout.
  - Afterwards, reads of 0x40 and 0x80 both miss.
- Flush during refill: raise flush in the middle of a 0x40 refill.
  - Required: refill finishes, then FLUSH runs; 0x40 ends up invalid.
- Reset mid-refill: assert RST after the first word is accepted.
  - Required next cycle: iREN=0, iaddr=0, counters=0; a read of 0x40 misses.
- Saturation (CNT_W=2): 5 consecutive hit cycles → hit_count=3 and stays 3.
